ppr_topk_select: RTL and testbench
==================================

// Module: ppr_topk_select
// PURPOSE
//   Downstream consumer of the diffusion_rw score table. After diffusion asserts finished, scans the
//   node_num score words starting at node_offset and keeps the K highest-scoring node ids, sorted.
//   Results drive the host readback / next MeLoPPR stage. Shares the score port, so it honours conflict.
// PARAMETERS
//   ADDR_WIDTH   13  score memory address width; also node id width
//   DATA_WIDTH   32  score word width, unsigned
//   node_num     1   number of score entries to scan (>=1)
//   node_offset  0   base address of score table
//   K            4   result depth (>=1)
// PORTS
//   clk          in   1               system clock, rising edge
//   rst          in   1               synchronous, active-high reset
//   start        in   1               begin scan (tie to diffusion_rw finished); sampled in IDLE only
//   conflict     in   1               score port busy: read not granted this cycle
//   data_in_s    in   DATA_WIDTH      score read data, 1-cycle latency after granted read
//   address_s    out  ADDR_WIDTH      score read address
//   rd_en_s      out  1               read request; granted when rd_en_s & ~conflict
//   busy         out  1               scan in progress
//   done         out  1               one-cycle pulse, results final
//   topk_id      out  K*ADDR_WIDTH    slot j at [j*ADDR_WIDTH +: ADDR_WIDTH], slot 0 = highest
//   topk_score   out  K*DATA_WIDTH    slot j score, same packing
//   topk_valid   out  K               slot j holds a real node
// BEHAVIOUR
//   Reset: state IDLE; address_s=0, rd_en_s=0, busy=0, done=0, all topk_score=0, topk_id=all-ones,
//     topk_valid=0. Reset mid-scan aborts immediately, same values; in-flight read data discarded.
//   FSM: IDLE -> SCAN (start=1) -> DRAIN (last address granted) -> DONE (last data inserted) -> IDLE.
//   IDLE: start clears all slots to reset values, idx=0. start in other states ignored.
//   SCAN: rd_en_s=1, address_s=node_offset+idx. Granted read -> idx++; conflict=1 -> hold address, no
//     advance, no data next cycle. Grant of idx=node_num-1 -> DRAIN.
//   Data pipe: pend<=grant; when pend=1, data_in_s is score of node id (granted address - node_offset).
//   DRAIN: rd_en_s=0; waits for pend data, inserts, -> DONE. DONE: done=1 one cycle, busy=0, -> IDLE.
//   busy=1 in SCAN and DRAIN only.
//   Insertion (one per cycle, combinational compare, registered update): new score s enters iff
//     s > topk_score[K-1] (unsigned, strict). Position p = first slot with s > topk_score[p]; slots
//     p..K-2 shift down one, slot K-1 dropped; slot p gets (id,s), valid=1.
//   Ties: equal score never overtakes; lower id (scanned first) stays ahead.
//   Zero scores never enter (strict > vs initial 0): unfilled slots keep valid=0, id all-ones.
//   node_num < K: slots beyond inserted count stay invalid.
//   Results hold from DONE until next accepted start or rst.
//   Latency, no conflict: start at edge 0 -> address idx in cycle 1+idx, data cycle 2+idx,
//     done high in cycle node_num+2. Each conflict cycle during SCAN adds exactly one cycle.
//   address_s arithmetic modulo 2^ADDR_WIDTH; node_offset+node_num must not exceed 2^ADDR_WIDTH.
// TESTING
//   T1 node_num=6,K=4, scores [5,9,0,9,3,7] -> id [1,3,5,0], score [9,9,7,5], valid 1111, done cycle 8.
//   T2 same as T1, conflict=1 for cycles 2-4 -> address 1 held 3 extra cycles, identical results,
//      done cycle 11, no duplicate insert of node 1.
//   T3 all scores 0 -> topk_valid=0000, ids all-ones, done still pulses once.
//   T4 node_num=2,K=4, scores [4,8] -> id [1,0,FFF..,FFF..], valid 0011.
//   T5 rst=1 in cycle 3 of T1 scan -> next cycle busy=0, valid=0000, rd_en_s=0; restart gives T1 result.
//   T6 start pulsed again mid-scan -> ignored, result and done timing equal to T1.

Source files
------------

// File: rtl/ppr_topk_select.sv
`default_nettype none
// ============================================================================
//  Module   : ppr_topk_select
//  Purpose  : Scans the diffusion score table once per start and keeps the K
//             highest-scoring node ids, sorted high-to-low (ties keep the
//             lower id ahead). Shares the score port and honours conflict.
//  Revision : 1.0 - initial release
// ============================================================================
module ppr_topk_select #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int node_num    = 1,
    parameter int node_offset = 0,
    parameter int K           = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    conflict,
    input  logic [DATA_WIDTH-1:0]   data_in_s,
    output logic [ADDR_WIDTH-1:0]   address_s,
    output logic                    rd_en_s,
    output logic                    busy,
    output logic                    done,
    output logic [K*ADDR_WIDTH-1:0] topk_id,
    output logic [K*DATA_WIDTH-1:0] topk_score,
    output logic [K-1:0]            topk_valid
);

    // State encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_scan  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Last scan index and table base, reduced to the address width
    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(node_num - 1);
    localparam logic [ADDR_WIDTH-1:0] c_base     = ADDR_WIDTH'(node_offset);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_id;

    // Result table, slot 0 holds the highest score
    logic [DATA_WIDTH-1:0] r_score [K];
    logic [ADDR_WIDTH-1:0] r_id    [K];
    logic [K-1:0]          r_valid;

    logic                  w_grant;
    logic                  w_clear;
    logic                  w_insert;
    logic [K-1:0]          w_gt;
    logic [DATA_WIDTH-1:0] w_nxt_score [K];
    logic [ADDR_WIDTH-1:0] w_nxt_id    [K];
    logic [K-1:0]          w_nxt_valid;

    assign w_grant  = r_rd_en & ~conflict;
    assign w_clear  = (r_state == c_st_idle) & start;
    assign w_insert = r_pend & ((r_state == c_st_scan) | (r_state == c_st_drain));

    // Per-slot insertion network. Because the table is kept sorted, w_gt is a
    // thermometer: the first set bit is the insertion point, every later set
    // bit shifts down from its predecessor. Strict > means ties never overtake
    // and zero scores never displace the empty (score 0) slots.
    generate
        for (genvar j = 0; j < K; j++) begin : g_slot
            assign w_gt[j] = data_in_s > r_score[j];

            if (j == 0) begin : g_head
                assign w_nxt_score[j] = w_gt[j] ? data_in_s : r_score[j];
                assign w_nxt_id[j]    = w_gt[j] ? r_pend_id : r_id[j];
                assign w_nxt_valid[j] = w_gt[j] | r_valid[j];
            end else begin : g_tail
                logic w_take;
                logic w_shift;
                assign w_take  = w_gt[j] & ~w_gt[j-1];
                assign w_shift = w_gt[j] &  w_gt[j-1];
                assign w_nxt_score[j] = w_take ? data_in_s :
                                        w_shift ? r_score[j-1] : r_score[j];
                assign w_nxt_id[j]    = w_take ? r_pend_id :
                                        w_shift ? r_id[j-1] : r_id[j];
                assign w_nxt_valid[j] = w_take | (w_shift ? r_valid[j-1] : r_valid[j]);
            end

            assign topk_id[j*ADDR_WIDTH +: ADDR_WIDTH]    = r_id[j];
            assign topk_score[j*DATA_WIDTH +: DATA_WIDTH] = r_score[j];
        end
    endgenerate

    assign topk_valid = r_valid;
    assign address_s  = r_addr;
    assign rd_en_s    = r_rd_en;
    assign busy       = r_busy;
    assign done       = r_done;

    // Control FSM: issues reads, tracks the one-cycle read-data pipe, and
    // produces the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_idx     <= '0;
            r_addr    <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_id <= '0;
        end else begin
            r_done    <= 1'b0;
            r_pend    <= w_grant;
            r_pend_id <= r_idx;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_addr  <= c_base;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= c_st_scan;
                    end
                end
                c_st_scan: begin
                    if (w_grant) begin
                        if (r_idx == c_last_idx) begin
                            r_rd_en <= 1'b0;
                            r_state <= c_st_drain;
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    if (r_pend) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Result table update: cleared on reset or accepted start, otherwise one
    // sorted insertion per returned score word.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            for (int j = 0; j < K; j++) begin
                r_score[j] <= '0;
                r_id[j]    <= '1;
            end
            r_valid <= '0;
        end else if (w_insert) begin
            for (int j = 0; j < K; j++) begin
                r_score[j] <= w_nxt_score[j];
                r_id[j]    <= w_nxt_id[j];
            end
            r_valid <= w_nxt_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppr_topk_select.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppr_topk_select
//  Purpose  : Self-checking bench for ppr_topk_select. Two instances (6 nodes
//             at offset 100, 2 nodes at the top of the address space) share
//             stimulus; results are checked against a selection-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ppr_topk_select;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int K  = 4;
    localparam int NA = 6;
    localparam int OA = 100;
    localparam int NB = 2;
    localparam int OB = 8190;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic conflict;

    logic [DW-1:0]   din_a, din_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic            rd_a, rd_b, busy_a, busy_b, done_a, done_b;
    logic [K*AW-1:0] id_a, id_b;
    logic [K*DW-1:0] sc_a, sc_b;
    logic [K-1:0]    v_a, v_b;

    ppr_topk_select #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .node_num(NA),
                      .node_offset(OA), .K(K)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .conflict(conflict),
        .data_in_s(din_a), .address_s(addr_a), .rd_en_s(rd_a),
        .busy(busy_a), .done(done_a), .topk_id(id_a), .topk_score(sc_a),
        .topk_valid(v_a));

    ppr_topk_select #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .node_num(NB),
                      .node_offset(OB), .K(K)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .conflict(conflict),
        .data_in_s(din_b), .address_s(addr_b), .rd_en_s(rd_b),
        .busy(busy_b), .done(done_b), .topk_id(id_b), .topk_score(sc_b),
        .topk_valid(v_b));

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            confl [0:255];

    logic [AW-1:0] exp_id [2][K];
    logic [DW-1:0] exp_sc [2][K];
    logic          exp_v  [2][K];

    // Score memory: one-cycle read latency, only granted reads return data
    always @(posedge clk) begin
        if (rd_a && !conflict) din_a <= mem[addr_a];
        if (rd_b && !conflict) din_b <= mem[addr_b];
    end

    // Reference: repeatedly select the highest positive score not yet taken,
    // lowest id winning ties; leftover slots are empty.
    task automatic model_topk(input int inst, input int n, input int off);
        bit used [0:15];
        int best;
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
        for (int j = 0; j < K; j++) begin
            best = -1;
            for (int i = 0; i < n; i++)
                if (!used[i] && mem[off+i] > 0 &&
                    (best < 0 || mem[off+i] > mem[off+best])) best = i;
            if (best >= 0) begin
                used[best]       = 1'b1;
                exp_id[inst][j] = AW'(best);
                exp_sc[inst][j] = mem[off+best];
                exp_v[inst][j]  = 1'b1;
            end else begin
                exp_id[inst][j] = '1;
                exp_sc[inst][j] = '0;
                exp_v[inst][j]  = 1'b0;
            end
        end
    endtask

    // Reference done cycle: one read is granted in each cycle without conflict
    function automatic int model_done(input int n);
        int idx = 0;
        for (int c = 1; c < 250; c++) begin
            if (!confl[c]) begin
                if (idx == n - 1) return c + 2;
                idx++;
            end
        end
        return -1;
    endfunction

    task automatic clear_confl();
        for (int c = 0; c < 256; c++) confl[c] = 1'b0;
    endtask

    task automatic load_mem(input int sa [NA], input int sb [NB]);
        for (int i = 0; i < NA; i++) mem[OA+i] = DW'(sa[i]);
        for (int i = 0; i < NB; i++) mem[OB+i] = DW'(sb[i]);
    endtask

    // One full scan on both instances; restart_cyc re-pulses start mid-scan
    task automatic run_scan(input string nm, input int restart_cyc);
        int da, db, got_a, got_b, cnt_a, cnt_b, limit;
        logic [AW-1:0] oid;
        logic [DW-1:0] osc;
        logic          ov;
        model_topk(0, NA, OA);
        model_topk(1, NB, OB);
        da = model_done(NA);
        db = model_done(NB);
        limit = ((da > db) ? da : db) + 3;
        got_a = -1; got_b = -1; cnt_a = 0; cnt_b = 0;
        @(negedge clk);
        start = 1'b1;
        conflict = confl[0];
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_cmp++;
                if (rd_a !== 1'b1 || addr_a !== AW'(OA) || busy_a !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s first_read: rd=%b addr=%0d busy=%b expected rd=1 addr=%0d busy=1",
                             nm, rd_a, addr_a, busy_a, OA);
                end
            end
            if (done_a) begin cnt_a++; if (got_a < 0) got_a = c; end
            if (done_b) begin cnt_b++; if (got_b < 0) got_b = c; end
            start    = (c == restart_cyc);
            conflict = confl[c];
        end
        start = 1'b0;
        conflict = 1'b0;
        n_cmp++;
        if (got_a !== da || cnt_a !== 1) begin
            n_bad++;
            $display("FAIL %s done_a: cycle %0d count %0d expected cycle %0d count 1", nm, got_a, cnt_a, da);
        end
        n_cmp++;
        if (got_b !== db || cnt_b !== 1) begin
            n_bad++;
            $display("FAIL %s done_b: cycle %0d count %0d expected cycle %0d count 1", nm, got_b, cnt_b, db);
        end
        n_cmp++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || rd_a !== 1'b0 || rd_b !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after: busy=%b%b rd=%b%b expected 0000", nm, busy_a, busy_b, rd_a, rd_b);
        end
        // Results must still hold several cycles after done
        for (int inst = 0; inst < 2; inst++) begin
            for (int j = 0; j < K; j++) begin
                oid = (inst == 0) ? id_a[j*AW +: AW] : id_b[j*AW +: AW];
                osc = (inst == 0) ? sc_a[j*DW +: DW] : sc_b[j*DW +: DW];
                ov  = (inst == 0) ? v_a[j] : v_b[j];
                n_cmp++;
                if (oid !== exp_id[inst][j] || osc !== exp_sc[inst][j] || ov !== exp_v[inst][j]) begin
                    n_bad++;
                    $display("FAIL %s slot%0d_inst%0d: id=%0h score=%0d valid=%b expected id=%0h score=%0d valid=%b",
                             nm, j, inst, oid, osc, ov, exp_id[inst][j], exp_sc[inst][j], exp_v[inst][j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; conflict = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (addr_a !== '0 || rd_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
            v_a !== '0 || id_a !== '1 || sc_a !== '0 || v_b !== '0 || id_b !== '1) begin
            n_bad++;
            $display("FAIL reset_state: addr=%0d rd=%b busy=%b done=%b valid=%b id=%0h score=%0h",
                     addr_a, rd_a, busy_a, done_a, v_a, id_a, sc_a);
        end
        rst = 1'b0;
    endtask

    task automatic test_t1_basic();
        clear_confl();
        load_mem('{5, 9, 0, 9, 3, 7}, '{4, 8});
        run_scan("t1_basic", -1);
    endtask

    task automatic test_t2_conflict();
        clear_confl();
        for (int c = 2; c <= 4; c++) confl[c] = 1'b1;
        load_mem('{5, 9, 0, 9, 3, 7}, '{4, 8});
        run_scan("t2_conflict", -1);
    endtask

    task automatic test_t3_zeros();
        clear_confl();
        load_mem('{0, 0, 0, 0, 0, 0}, '{0, 0});
        run_scan("t3_zeros", -1);
    endtask

    task automatic test_t5_reset_mid();
        clear_confl();
        load_mem('{5, 9, 0, 9, 3, 7}, '{4, 8});
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b0 || v_a !== '0 || rd_a !== 1'b0 || id_a !== '1 || done_a !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_reset_mid: busy=%b valid=%b rd=%b id=%0h done=%b expected 0 0000 0 all-ones 0",
                     busy_a, v_a, rd_a, id_a, done_a);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || v_a !== '0) begin
            n_bad++;
            $display("FAIL t5_quiet_after_reset: done=%b busy=%b valid=%b expected 0 0 0000", done_a, busy_a, v_a);
        end
        run_scan("t5_restart", -1);
    endtask

    task automatic test_t6_restart_ignored();
        clear_confl();
        load_mem('{5, 9, 0, 9, 3, 7}, '{4, 8});
        run_scan("t6_restart_ignored", 3);
    endtask

    task automatic test_random();
        int sa [NA];
        int sb [NB];
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 256; c++) confl[c] = ($urandom_range(0, 3) == 0);
            confl[0] = 1'b0;
            for (int i = 0; i < NA; i++)
                sa[i] = (it < 4) ? int'($urandom_range(0, 5)) : int'($urandom);
            for (int i = 0; i < NB; i++) sb[i] = int'($urandom_range(0, 3));
            load_mem(sa, sb);
            run_scan($sformatf("random_%0d", it), -1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; conflict = 1'b0;
        din_a = '0; din_b = '0;
        test_reset();
        test_t1_basic();
        test_t2_conflict();
        test_t3_zeros();
        test_t5_reset_mid();
        test_t6_restart_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
